apb_cfg_bridge: RTL and testbench

- APB slave front-end that sits directly upstream of the coefficient/control register bank.
- Converts a standard APB transfer (PSEL/PENABLE/PREADY/PSLVERR) into the bank's one-hot block-enable protocol.
- Decodes the address into the FRAC_DECI/IIR/CIC/CTRL/FIR enable, sequences the bank's two-phase access, and returns read data.
- Flags undecoded addresses and unresponsive accesses with PSLVERR.

---
 rtl/apb_cfg_bridge_if.sv | 51 +++++
 rtl/apb_cfg_bridge.sv | 175 +++++++++++++++++
 tb/tb_apb_cfg_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cfg_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_cfg_bridge_if
// Bundles the APB slave port and the register-bank block-enable port of the
// APB configuration bridge.
//   APB side : PSEL, PENABLE, PWRITE, PADDR, PWDATA -> bridge
//              PREADY, PRDATA, PSLVERR               <- bridge
//   Bank side: FRAC_DECI_EN, IIR_EN, CIC_EN, CTRL_EN, FIR_EN, RAM_PWRITE,
//              RAM_PENABLE, DATA_ADDR, DATA_IN       <- bridge
//              RAM_PREADY, RAM_PRDATA                -> bridge
// Modport slave is the bridge's view; master is the view of whatever drives
// the APB bus and models the bank.
// ---------------------------------------------------------------------------
interface apb_cfg_bridge_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  logic                  FRAC_DECI_EN;
  logic                  IIR_EN;
  logic                  CIC_EN;
  logic                  CTRL_EN;
  logic                  FIR_EN;
  logic                  RAM_PWRITE;
  logic                  RAM_PENABLE;
  logic [ADDR_WIDTH-1:0] DATA_ADDR;
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic                  RAM_PREADY;
  logic [DATA_WIDTH-1:0] RAM_PRDATA;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, RAM_PREADY, RAM_PRDATA,
    output PREADY, PRDATA, PSLVERR,
    output FRAC_DECI_EN, IIR_EN, CIC_EN, CTRL_EN, FIR_EN,
    output RAM_PWRITE, RAM_PENABLE, DATA_ADDR, DATA_IN
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, RAM_PREADY, RAM_PRDATA,
    input  PREADY, PRDATA, PSLVERR,
    input  FRAC_DECI_EN, IIR_EN, CIC_EN, CTRL_EN, FIR_EN,
    input  RAM_PWRITE, RAM_PENABLE, DATA_ADDR, DATA_IN
  );
endinterface

// File: rtl/apb_cfg_bridge.sv
// ---------------------------------------------------------------------------
// apb_cfg_bridge
// APB slave front-end for the coefficient/control register bank. Decodes the
// APB address into one of five one-hot bank enables, runs the bank's
// two-phase access (enable, then a one-cycle RAM_PENABLE commit for writes),
// and returns read data / error on the APB side.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : apb_cfg_bridge_if.slave (APB slave + bank master signals)
//   state_dbg  : current FSM state (0 IDLE, 1 REQ, 2 WR, 3 RESP)
//
// Handshake: an APB transfer is a setup cycle (PSEL & !PENABLE) followed by
// access cycles (PSEL & PENABLE) that end on the cycle PREADY=1; PSLVERR and
// PRDATA are only meaningful in that cycle. On the bank side an enable is held
// until the bank answers with RAM_PREADY for one cycle; RAM_PRDATA is valid
// only in that cycle.
// ---------------------------------------------------------------------------
module apb_cfg_bridge #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 72,
  parameter int NUM_DENUM  = 5,
  parameter int TIMEOUT    = 8
) (
  input  logic             clk,
  input  logic             rst,
  apb_cfg_bridge_if.slave  bus,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // One-hot enable vector bit positions.
  localparam int EN_FRAC = 0;
  localparam int EN_IIR  = 1;
  localparam int EN_CIC  = 2;
  localparam int EN_CTRL = 3;
  localparam int EN_FIR  = 4;

  localparam logic [31:0] TAPS_L = 32'(TAPS);
  localparam logic [31:0] B_L    = 32'(TAPS + NUM_DENUM);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  write_q;
  logic [4:0]            en_q;
  logic                  err_q;
  logic                  hold_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [4:0]            dec_en;
  logic [31:0]           dec_a;
  logic                  setup;
  logic                  timed_out;

  assign setup     = bus.PSEL & ~bus.PENABLE;
  assign timed_out = (cnt_q == CNT_LAST) & ~bus.RAM_PREADY;

  // Address decode; all-zero result means the address is not mapped.
  always_comb begin
    dec_en = '0;
    dec_a  = 32'(bus.PADDR);
    if (dec_a < TAPS_L)               dec_en[EN_FRAC] = 1'b1;
    else if (dec_a < B_L)             dec_en[EN_IIR]  = 1'b1;
    else if (dec_a == B_L)            dec_en[EN_CIC]  = 1'b1;
    else if (dec_a <= B_L + 32'd6)    dec_en[EN_CTRL] = 1'b1;
    else if (dec_a <= B_L + 32'd8)    dec_en[EN_FRAC] = 1'b1;
    else if (dec_a <= B_L + 32'd14)   dec_en[EN_IIR]  = 1'b1;
    else if (dec_a <= B_L + 32'd16)   dec_en[EN_CIC]  = 1'b1;
    else if (dec_a <= B_L + 32'd18)   dec_en[EN_FIR]  = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Dropping PSEL abandons the transfer from REQ/RESP;
  // WR always finishes so a commit is never cut in half.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (setup) state_d = (dec_en != '0) ? S_REQ : S_RESP;
      end
      S_REQ: begin
        if (!bus.PSEL)             state_d = S_IDLE;
        else if (bus.RAM_PREADY)   state_d = write_q ? S_WR : S_RESP;
        else if (timed_out)        state_d = S_RESP;
      end
      S_WR: state_d = S_RESP;
      S_RESP: begin
        if (!bus.PSEL)                                 state_d = S_IDLE;
        else if (bus.PENABLE && !hold_q)               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer registers: latched at setup, read data at bank ready, wait count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      en_q    <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // hold_q is a single-cycle marker; only the decode-error path sets it.
      hold_q <= 1'b0;
      if (state_q == S_IDLE && setup) begin
        addr_q  <= bus.PADDR;
        wdata_q <= bus.PWDATA;
        write_q <= bus.PWRITE;
        en_q    <= dec_en;
        err_q   <= (dec_en == '0);
        // Unmapped addresses answer one cycle into RESP so the error
        // response lands at a fixed point, two cycles after setup.
        hold_q  <= (dec_en == '0);
        rdata_q <= '0;
        cnt_q   <= '0;
      end else if (state_q == S_REQ && bus.PSEL) begin
        if (bus.RAM_PREADY) begin
          // The bank clears RAM_PRDATA after its ready cycle.
          if (!write_q) rdata_q <= bus.RAM_PRDATA;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (timed_out) err_q <= 1'b1;
        end
      end
    end
  end

  // Outputs, decoded from the current state only.
  logic                  bank_act;
  logic                  pready;
  logic [4:0]            en_out;

  always_comb begin
    bank_act = (state_q == S_REQ) || (state_q == S_WR);
    pready   = (state_q == S_RESP) & bus.PSEL & bus.PENABLE & ~hold_q;
    en_out   = bank_act ? en_q : 5'b0;
  end

  assign bus.PREADY       = pready;
  assign bus.PSLVERR      = pready & err_q;
  assign bus.PRDATA       = (pready && !err_q && !write_q) ? rdata_q : '0;
  assign bus.FRAC_DECI_EN = en_out[EN_FRAC];
  assign bus.IIR_EN       = en_out[EN_IIR];
  assign bus.CIC_EN       = en_out[EN_CIC];
  assign bus.CTRL_EN      = en_out[EN_CTRL];
  assign bus.FIR_EN       = en_out[EN_FIR];
  assign bus.RAM_PWRITE   = bank_act & write_q;
  // WR is only reachable for writes, so RAM_PWRITE is high whenever this is.
  assign bus.RAM_PENABLE  = (state_q == S_WR);
  assign bus.DATA_ADDR    = bank_act ? addr_q : '0;
  assign bus.DATA_IN      = bank_act ? wdata_q : '0;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_apb_cfg_bridge.sv
module tb_apb_cfg_bridge;

  localparam int AW = 7;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_cfg_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [1:0] state_dbg;

  apb_cfg_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bank model ----------------
  // Answers RAM_PREADY for one cycle, one cycle after it sees an enable.
  logic          bank_on   = 1'b1;
  logic [DW-1:0] bank_data = '0;
  logic [4:0]    en_vec;
  assign en_vec = {bus.FIR_EN, bus.CTRL_EN, bus.CIC_EN, bus.IIR_EN, bus.FRAC_DECI_EN};

  always begin : bank_model
    logic pend;
    @(negedge clk);
    pend = (en_vec != 5'b0) && !bus.RAM_PENABLE && !bus.RAM_PREADY && !rst;
    @(posedge clk);
    #1;
    bus.RAM_PREADY = pend & bank_on;
    bus.RAM_PRDATA = (pend & bank_on) ? bank_data : '0;
  end

  // ---------------- global protocol monitors ----------------
  int bad_pen   = 0;
  int bad_rdy   = 0;
  int bad_hot   = 0;
  int pen_total = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.RAM_PENABLE && !bus.RAM_PWRITE) bad_pen++;
      if (bus.PREADY && state_dbg != 2'd3)    bad_rdy++;
      if ($countones(en_vec) > 1)             bad_hot++;
      if (bus.RAM_PENABLE)                    pen_total++;
    end
  end

  // ---------------- driver ----------------
  int            r_rdy;
  logic [DW-1:0] r_rd;
  logic          r_err;
  logic [4:0]    r_en;
  int            r_en_first, r_en_last;
  int            r_pen_cnt, r_pen_cyc;
  logic [AW-1:0] r_pen_addr;
  logic [DW-1:0] r_pen_data;

  // Caller is just after a posedge. Cycle 0 is the setup phase. Returns just
  // after the posedge that ends the PREADY cycle, with the bus idle.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int cyc;
    r_rdy = -1; r_rd = '0; r_err = 1'b0; r_en = '0;
    r_en_first = -1; r_en_last = -1;
    r_pen_cnt = 0; r_pen_cyc = -1; r_pen_addr = '0; r_pen_data = '0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wd;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (en_vec != 5'b0) begin
        r_en = r_en | en_vec;
        if (r_en_first < 0) r_en_first = cyc;
        r_en_last = cyc;
      end
      if (bus.RAM_PENABLE) begin
        r_pen_cnt++;
        r_pen_cyc  = cyc;
        r_pen_addr = bus.DATA_ADDR;
        r_pen_data = bus.DATA_IN;
      end
      if (bus.PREADY) begin
        r_rdy = cyc;
        r_rd  = bus.PRDATA;
        r_err = bus.PSLVERR;
      end
      @(posedge clk);
      #1;
      if (r_rdy >= 0) break;
      bus.PENABLE = 1'b1;
    end
    if (r_rdy < 0) $display("FAIL xfer_timeout: addr %0d no PREADY within 30 cycles", addr);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] dec_addr [10];
  logic [4:0]    dec_exp  [10];
  int            pen_before;

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    bus.RAM_PREADY = 1'b0; bus.RAM_PRDATA = '0;

    dec_addr = '{7'd71, 7'd72, 7'd76, 7'd78, 7'd84, 7'd85, 7'd86, 7'd92, 7'd94, 7'd96};
    dec_exp  = '{5'h01, 5'h02, 5'h02, 5'h08, 5'h01, 5'h01, 5'h02, 5'h04, 5'h10, 5'h00};

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'(|{bus.PREADY, bus.PSLVERR, bus.PRDATA, en_vec, bus.RAM_PWRITE,
                              bus.RAM_PENABLE, bus.DATA_ADDR, bus.DATA_IN}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Write 5 -> FRAC_DECI
    apb_xfer(1'b1, 7'd5, 32'h0001_2345);
    check("w5_rdy_cyc",   r_rdy, 4);
    check("w5_err",       32'(r_err), 0);
    check("w5_en",        32'(r_en), 32'h01);
    check("w5_en_first",  r_en_first, 1);
    check("w5_en_last",   r_en_last, 3);
    check("w5_pen_cnt",   r_pen_cnt, 1);
    check("w5_pen_cyc",   r_pen_cyc, 3);
    check("w5_pen_addr",  32'(r_pen_addr), 5);
    check("w5_pen_data",  r_pen_data, 32'h0001_2345);
    check("w5_prdata",    r_rd, 0);
    idle_cycles(1);

    // Read 74 -> IIR
    bank_data = 32'h0000_0ABC;
    apb_xfer(1'b0, 7'd74, 32'h0);
    check("r74_rdy_cyc",  r_rdy, 3);
    check("r74_prdata",   r_rd, 32'h0000_0ABC);
    check("r74_en",       32'(r_en), 32'h02);
    check("r74_pen_cnt",  r_pen_cnt, 0);
    check("r74_err",      32'(r_err), 0);
    idle_cycles(1);

    // Read 100 -> unmapped
    apb_xfer(1'b0, 7'd100, 32'h0);
    check("r100_rdy_cyc", r_rdy, 2);
    check("r100_err",     32'(r_err), 1);
    check("r100_prdata",  r_rd, 0);
    check("r100_en",      32'(r_en), 0);
    idle_cycles(1);

    // Write 77 with a silent bank -> timeout
    bank_on = 1'b0;
    apb_xfer(1'b1, 7'd77, 32'hDEAD_BEEF);
    check("w77_en",       32'(r_en), 32'h04);
    check("w77_en_first", r_en_first, 1);
    check("w77_en_last",  r_en_last, 8);
    check("w77_rdy_cyc",  r_rdy, 9);
    check("w77_err",      32'(r_err), 1);
    check("w77_pen_cnt",  r_pen_cnt, 0);
    bank_on = 1'b1;
    idle_cycles(1);

    // Back-to-back: read 83 (CTRL) then write 95 (FIR)
    bank_data = 32'h0000_5A5A;
    apb_xfer(1'b0, 7'd83, 32'h0);
    check("r83_en",       32'(r_en), 32'h08);
    check("r83_prdata",   r_rd, 32'h0000_5A5A);
    check("r83_rdy_cyc",  r_rdy, 3);
    apb_xfer(1'b1, 7'd95, 32'h0000_00F5);
    check("w95_en",       32'(r_en), 32'h10);
    check("w95_rdy_cyc",  r_rdy, 4);
    check("w95_pen_addr", 32'(r_pen_addr), 95);
    check("w95_err",      32'(r_err), 0);
    idle_cycles(1);

    // Decode boundaries
    bank_data = 32'h0000_0011;
    for (int i = 0; i < 10; i++) begin
      apb_xfer(1'b0, dec_addr[i], 32'h0);
      check($sformatf("dec_en_%0d", dec_addr[i]), 32'(r_en), 32'(dec_exp[i]));
      check($sformatf("dec_err_%0d", dec_addr[i]), 32'(r_err), 32'(dec_exp[i] == 5'h00));
      idle_cycles(1);
    end

    // Reset during REQ of a write to 10
    pen_before = pen_total;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 7'd10; bus.PWDATA = 32'h0000_1010;
    @(posedge clk);
    #1;
    bus.PENABLE = 1'b1;
    check("rq_state_req", 32'(state_dbg), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rq_async_outputs", 32'(|{bus.PREADY, bus.PSLVERR, bus.PRDATA, en_vec, bus.RAM_PWRITE,
                                   bus.RAM_PENABLE, bus.DATA_ADDR, bus.DATA_IN}), 32'd0);
    check("rq_async_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    rst = 1'b0;
    idle_cycles(3);
    check("rq_no_commit", pen_total, pen_before);
    apb_xfer(1'b1, 7'd10, 32'h0000_1010);
    check("rq_next_rdy",  r_rdy, 4);
    check("rq_next_pen",  r_pen_cnt, 1);
    check("rq_next_addr", 32'(r_pen_addr), 10);
    check("rq_next_en",   32'(r_en), 32'h01);
    idle_cycles(2);

    // Protocol invariants over the whole run
    check("mon_penable_without_pwrite", bad_pen, 0);
    check("mon_pready_outside_resp",    bad_rdy, 0);
    check("mon_enable_not_onehot",      bad_hot, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: stimulus did not complete");
    $fatal(1, "global timeout");
  end

endmodule
